// File: rtl/crt_pkg.sv
// rtl/crt_pkg.sv - shared state encoding and default sizing for the blanking-window scheduler.
package crt_pkg;

  localparam int CRT_N_REQ    = 4;
  localparam int CRT_YW       = 10;
  localparam int CRT_MAX_HOLD = 255;
  localparam int CRT_FCW      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BUSY = 2'd2
  } crt_state_e;

endpackage

// File: rtl/crt_rr_pick.sv
// rtl/crt_rr_pick.sv - combinational rotate-priority picker: first set request at or after ptr.
module crt_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    index,
  output logic             any
);

  logic [IW-1:0] cand;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        index        = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crt_blank_scheduler.sv
// rtl/crt_blank_scheduler.sv - grants the shared object-update port round-robin, only while the
// CRT is in vertical blanking; also tracks frames, forced releases and missed requesters.
module crt_blank_scheduler
  import crt_pkg::*;
#(
  parameter int N_REQ    = CRT_N_REQ,
  parameter int YW       = CRT_YW,
  parameter int MAX_HOLD = CRT_MAX_HOLD,
  parameter int FCW      = CRT_FCW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [YW-1:0]    Yresolution,
  input  logic [YW-1:0]    yposition,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             clr_missed,
  output logic [N_REQ-1:0] grant,
  output logic             in_blank,
  output logic             frame_tick,
  output logic [FCW-1:0]   frame_count,
  output logic             timeout,
  output logic [N_REQ-1:0] missed
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  crt_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_blank_q, in_blank_d;
  logic             frame_tick_q, frame_tick_d;
  logic [FCW-1:0]   frame_count_q, frame_count_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] missed_q, missed_d;

  logic             blank_now;
  logic             window_close;
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  crt_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Blanking detect, frame counting and missed-request bookkeeping.
  always_comb begin
    blank_now     = (yposition >= Yresolution);
    window_close  = ~blank_now & in_blank_q;
    in_blank_d    = blank_now;
    frame_tick_d  = blank_now & ~in_blank_q;
    frame_count_d = frame_tick_d ? frame_count_q + FCW'(1) : frame_count_q;
    missed_d      = (clr_missed ? '0 : missed_q) | (window_close ? (req & ~grant_q) : '0);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (in_blank_q && |req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // A release strobe on the final hold cycle is a normal release, not a timeout.
        if (|(done & grant_q)) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (cnt_d == CW'(MAX_HOLD)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      in_blank_q    <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      timeout_q     <= 1'b0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      in_blank_q    <= in_blank_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
      missed_q      <= missed_d;
    end
  end

  assign grant       = grant_q;
  assign in_blank    = in_blank_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign timeout     = timeout_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_crt_blank_scheduler.sv
// tb/tb_crt_blank_scheduler.sv - scoreboard bench for crt_blank_scheduler (Yresolution=4, MAX_HOLD=8).
module tb_crt_blank_scheduler;

  logic        clock;
  logic        reset;
  logic [9:0]  Yresolution;
  logic [9:0]  yposition;
  logic [3:0]  req;
  logic [3:0]  done;
  logic        clr_missed;
  logic [3:0]  grant;
  logic        in_blank;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic        timeout;
  logic [3:0]  missed;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  g_prev = '0;

  crt_blank_scheduler #(
    .N_REQ    (4),
    .YW       (10),
    .MAX_HOLD (8),
    .FCW      (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Yresolution (Yresolution),
    .yposition   (yposition),
    .req         (req),
    .done        (done),
    .clr_missed  (clr_missed),
    .grant       (grant),
    .in_blank    (in_blank),
    .frame_tick  (frame_tick),
    .frame_count (frame_count),
    .timeout     (timeout),
    .missed      (missed)
  );

  initial clock = 1'b0;
  always #1 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every fresh grant is popped against the expected arbitration order.
  always @(negedge clock) begin
    if (reset && grant != '0 && grant != g_prev) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 32'(grant), 32'h0);
      else                   chk("grant_seq", 32'(grant), 32'(exp_q.pop_front()));
    end
    g_prev <= grant;
  end

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    while (grant == '0 && n < 12) begin
      @(negedge clock);
      n++;
    end
    if (grant == '0) chk({"wait_", tag}, 32'(grant), 32'(exp));
  endtask

  task automatic serve(input logic [3:0] who, input logic [3:0] nxt);
    repeat (3) @(negedge clock);
    done = who;
    req  = nxt;
    @(negedge clock);
    done = '0;
    chk("released", 32'(grant), 32'h0);
  endtask

  logic [3:0] seq [4];
  int         held;
  logic [3:0] seen;
  time        t_rst;

  initial begin
    reset       = 1'b0;
    Yresolution = 10'd4;
    yposition   = 10'd0;
    req         = 4'b1111;
    done        = '0;
    clr_missed  = 1'b0;

    // 1: reset holds everything at zero; no grant outside blanking
    @(negedge clock);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_in_blank", 32'(in_blank), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_count", 32'(frame_count), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_missed", 32'(missed), 32'h0);
    #3 reset = 1'b1;
    for (int y = 0; y < 4; y++) begin
      yposition = 10'(y);
      @(negedge clock);
      chk("t1_no_grant", 32'(grant), 32'h0);
    end

    // 2: entering blanking
    req       = 4'b0001;
    yposition = 10'd4;
    exp_q.push_back(4'b0001);
    @(negedge clock);
    chk("t2_in_blank", 32'(in_blank), 32'h1);
    chk("t2_tick", 32'(frame_tick), 32'h1);
    chk("t2_count", 32'(frame_count), 32'h1);
    chk("t2_grant_e1", 32'(grant), 32'h0);
    yposition = 10'd5;
    @(negedge clock);
    chk("t2_tick_1cyc", 32'(frame_tick), 32'h0);
    chk("t2_grant_e2", 32'(grant), 32'h0);
    @(negedge clock);
    chk("t2_grant_lat", 32'(grant), 32'h1);
    serve(4'b0001, 4'b1111);

    // 3: round robin with all requesting
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 4; i++) begin
      wait_grant("t3", seq[i]);
      serve(seq[i], (i == 3) ? 4'b0100 : 4'b1111);
    end

    // 4: forced release after MAX_HOLD cycles, then regrant
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    wait_grant("t4", 4'b0100);
    held = 0;
    while (grant == 4'b0100 && held < 20) begin
      held++;
      @(negedge clock);
    end
    chk("t4_hold_cycles", 32'(held), 32'd8);
    chk("t4_timeout", 32'(timeout), 32'h1);
    chk("t4_gap0", 32'(grant), 32'h0);
    @(negedge clock);
    chk("t4_timeout_once", 32'(timeout), 32'h0);
    chk("t4_gap1", 32'(grant), 32'h0);
    @(negedge clock);
    chk("t4_regrant", 32'(grant), 32'h4);
    serve(4'b0100, 4'b0011);

    // 5: window closes mid-grant
    exp_q.push_back(4'b0001);
    wait_grant("t5", 4'b0001);
    yposition = 10'd0;
    @(negedge clock);
    chk("t5_in_blank", 32'(in_blank), 32'h0);
    chk("t5_missed", 32'(missed), 32'h2);
    chk("t5_grant_kept", 32'(grant), 32'h1);
    repeat (2) @(negedge clock);
    chk("t5_grant_held", 32'(grant), 32'h1);
    done = 4'b0001;
    @(negedge clock);
    done = '0;
    seen = grant;
    for (int y = 1; y < 4; y++) begin
      yposition = 10'(y);
      @(negedge clock);
      seen = seen | grant;
    end
    chk("t5_no_grant", 32'(seen), 32'h0);
    chk("t5_missed_sticky", 32'(missed), 32'h2);
    clr_missed = 1'b1;
    @(negedge clock);
    clr_missed = 1'b0;
    chk("t5_missed_clr", 32'(missed), 32'h0);

    // 6: asynchronous reset mid-grant
    yposition = 10'd5;
    exp_q.push_back(4'b0010);
    @(negedge clock);
    chk("t6_tick", 32'(frame_tick), 32'h1);
    chk("t6_count", 32'(frame_count), 32'h2);
    wait_grant("t6", 4'b0010);
    @(negedge clock);
    t_rst = $time;
    reset = 1'b0;
    fork
      wait (grant == '0 && frame_count == '0);
      #2;
    join_any
    disable fork;
    chk("t6_async_time", 32'($time - t_rst), 32'h0);
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_count_clr", 32'(frame_count), 32'h0);
    @(negedge clock);
    chk("t6_in_blank", 32'(in_blank), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
